servo_pwm_ramp: RTL and testbench

//  Servo pulse generator that sits downstream of the Avalon servo register.
//  It consumes the registered 'locked' level and drives the servo PWM pin at a fixed frame rate.

---
 rtl/servo_pwm_ramp.sv | 98 +++++++++
 tb/tb_servo_pwm_ramp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_ramp.sv
// servo_pwm_ramp
//   Servo PWM generator with a slew-limited pulse width. A microsecond
//   timebase divides clk by CLK_HZ/1e6; a frame is PERIOD_US microseconds.
//   At each frame boundary the pulse width moves toward the target selected
//   by 'locked' by at most STEP_US, clamped so it never overshoots.
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   locked       requested position (1 = lock, 0 = unlock), synchronous to clk
//   servo        registered PWM output
//   pulse_us     pulse width (us) applied in the current frame
//   busy         1 while the applied width differs from the target
//   frame_start  one-cycle pulse in the first cycle of each frame (not the first after reset)
module servo_pwm_ramp #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned LOCK_US   = 2000,
  parameter int unsigned UNLOCK_US = 1000,
  parameter int unsigned STEP_US   = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           locked,
  output logic                           servo,
  output logic [$clog2(PERIOD_US+1)-1:0] pulse_us,
  output logic                           busy,
  output logic                           frame_start
);

  localparam int unsigned DIV  = CLK_HZ / 1_000_000;
  localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW   = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int unsigned W    = $clog2(PERIOD_US + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PS_W-1:0] prescaler;
  logic [CW-1:0]   us_cnt;
  logic            us_tick;
  logic            boundary;
  logic [W-1:0]    target;
  logic [W-1:0]    diff;
  logic [W-1:0]    pulse_nxt;
  logic            go_up, go_down;

  assign us_tick  = (prescaler == PS_W'(DIV - 1));
  assign boundary = us_tick && (us_cnt == CW'(PERIOD_US - 1));
  assign target   = locked ? W'(LOCK_US) : W'(UNLOCK_US);

  // Next width and state. Direction is decided purely by target vs the
  // current width, so IDLE, RAMP_UP and RAMP_DOWN all resolve identically at
  // a boundary: step (clamped to target), then IDLE once the target is hit.
  always_comb begin
    state_nxt = state;
    pulse_nxt = pulse_us;
    go_up     = (target > pulse_us);
    go_down   = (target < pulse_us);
    diff      = go_up ? (target - pulse_us) : (pulse_us - target);
    if (boundary) begin
      if (go_up) begin
        pulse_nxt = (32'(diff) <= STEP_US) ? target : pulse_us + W'(STEP_US);
        state_nxt = (32'(diff) <= STEP_US) ? IDLE : RAMP_UP;
      end else if (go_down) begin
        pulse_nxt = (32'(diff) <= STEP_US) ? target : pulse_us - W'(STEP_US);
        state_nxt = (32'(diff) <= STEP_US) ? IDLE : RAMP_DOWN;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler   <= '0;
      us_cnt      <= '0;
      pulse_us    <= W'(UNLOCK_US);
      state       <= IDLE;
      busy        <= 1'b0;
      servo       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= us_tick ? '0 : prescaler + 1'b1;
      if (us_tick)
        us_cnt    <= (us_cnt == CW'(PERIOD_US - 1)) ? '0 : us_cnt + 1'b1;
      pulse_us    <= pulse_nxt;
      state       <= state_nxt;
      busy        <= (state_nxt != IDLE);
      servo       <= (W'(us_cnt) < pulse_us);
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_servo_pwm_ramp.sv
module tb_servo_pwm_ramp;

  localparam int unsigned WA = $clog2(250 + 1);
  localparam int unsigned WB = $clog2(100 + 1);
  localparam int unsigned WC = $clog2(20 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_a = 1'b1, locked_a = 1'b0, servo_a, busy_a, fs_a;
  logic [WA-1:0] pulse_a;
  logic          reset_b = 1'b1, locked_b = 1'b0, servo_b, busy_b, fs_b;
  logic [WB-1:0] pulse_b;
  logic          reset_c = 1'b1, locked_c = 1'b0, servo_c, busy_c, fs_c;
  logic [WC-1:0] pulse_c;

  int errors = 0;
  int checks = 0;

  // DIV=1, 250-cycle frame, ramp 100 -> 200 in steps of 20
  servo_pwm_ramp #(.CLK_HZ(1_000_000), .PERIOD_US(250), .LOCK_US(200),
                   .UNLOCK_US(100), .STEP_US(20)) dut_a (
    .clk(clk), .reset(reset_a), .locked(locked_a), .servo(servo_a),
    .pulse_us(pulse_a), .busy(busy_a), .frame_start(fs_a));

  // DIV=2, 200-cycle frame, widths 10 / 30, step 7
  servo_pwm_ramp #(.CLK_HZ(2_000_000), .PERIOD_US(100), .LOCK_US(30),
                   .UNLOCK_US(10), .STEP_US(7)) dut_b (
    .clk(clk), .reset(reset_b), .locked(locked_b), .servo(servo_b),
    .pulse_us(pulse_b), .busy(busy_b), .frame_start(fs_b));

  // LOCK_US == UNLOCK_US: never leaves IDLE
  servo_pwm_ramp #(.CLK_HZ(1_000_000), .PERIOD_US(20), .LOCK_US(10),
                   .UNLOCK_US(10), .STEP_US(3)) dut_c (
    .clk(clk), .reset(reset_c), .locked(locked_c), .servo(servo_c),
    .pulse_us(pulse_c), .busy(busy_c), .frame_start(fs_c));

  // Wait (bounded) for frame_start of instance a (which=0) or b (which=1).
  task automatic wait_fs(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((which == 0 && fs_a) || (which == 1 && fs_b)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int high;
    int early;
    reset_a = 1'b1; locked_a = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (servo_a !== 1'b0) begin errors++; $display("FAIL reset_servo got=%b exp=0", servo_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (pulse_a !== WA'(100)) begin errors++; $display("FAIL reset_pulse got=%0d exp=100", pulse_a); end
    checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", fs_a); end
    reset_a = 1'b0;
    high = 0; early = 0;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++; if (servo_a !== 1'b1) begin errors++; $display("FAIL reset_first_high got=%b exp=1", servo_a); end
      end
      if (servo_a === 1'b1) high++;
      if (i < 250 && fs_a === 1'b1) early++;
      if (i == 250) begin
        checks++; if (fs_a !== 1'b1) begin errors++; $display("FAIL reset_frame_end got=%b exp=1", fs_a); end
      end
    end
    checks++; if (high != 100) begin errors++; $display("FAIL reset_high_cycles got=%0d exp=100", high); end
    checks++; if (early != 0) begin errors++; $display("FAIL reset_no_first_fs got=%0d exp=0", early); end
  endtask

  task automatic test_lock_ramp;
    bit ok;
    reset_a = 1'b1; locked_a = 1'b1;
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      wait_fs(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ramp_timeout got=none exp=frame_start"); end
      checks++; if (pulse_a !== WA'(k < 5 ? 100 + 20 * k : 200)) begin
        errors++; $display("FAIL ramp_pulse frame=%0d got=%0d exp=%0d", k, pulse_a, k < 5 ? 100 + 20 * k : 200);
      end
      checks++; if (busy_a !== (k < 5)) begin
        errors++; $display("FAIL ramp_busy frame=%0d got=%b exp=%b", k, busy_a, k < 5);
      end
    end
  endtask

  task automatic test_reversal;
    bit ok;
    int exp_w[7] = '{17, 24, 17, 10, 17, 24, 30};
    bit exp_b[7] = '{1, 1, 1, 0, 1, 1, 0};
    reset_b = 1'b1; locked_b = 1'b1;
    repeat (3) @(negedge clk);
    reset_b = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wait_fs(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rev_timeout got=none exp=frame_start"); end
      checks++; if (pulse_b !== WB'(exp_w[k])) begin
        errors++; $display("FAIL rev_pulse step=%0d got=%0d exp=%0d", k, pulse_b, exp_w[k]);
      end
      checks++; if (busy_b !== exp_b[k]) begin
        errors++; $display("FAIL rev_busy step=%0d got=%b exp=%b", k, busy_b, exp_b[k]);
      end
      if (k == 1) locked_b = 1'b0;
      if (k == 3) locked_b = 1'b1;
    end
  endtask

  task automatic test_mid_frame;
    bit ok;
    int high;
    int moved;
    wait_fs(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got=none exp=frame_start"); end
    for (int f = 0; f < 2; f++) begin
      high = 0; moved = 0;
      for (int i = 1; i <= 200; i++) begin
        @(negedge clk);
        if (i < 200 && pulse_b !== WB'(30)) moved++;
        if (servo_b === 1'b1) high++;
        if (f == 0 && i == 50)  locked_b = 1'b0;
        if (f == 0 && i == 100) locked_b = 1'b1;
        if (f == 1 && i == 199) locked_b = 1'b0;
        if (i == 200) begin
          checks++; if (fs_b !== 1'b1) begin errors++; $display("FAIL mid_frame_len frame=%0d got=%b exp=1", f, fs_b); end
        end
      end
      checks++; if (moved != 0) begin errors++; $display("FAIL mid_pulse_moved frame=%0d got=%0d exp=0", f, moved); end
      checks++; if (high != 60) begin errors++; $display("FAIL mid_high frame=%0d got=%0d exp=60", f, high); end
      checks++; if (pulse_b !== WB'(f == 0 ? 30 : 23)) begin
        errors++; $display("FAIL mid_boundary_pulse frame=%0d got=%0d exp=%0d", f, pulse_b, f == 0 ? 30 : 23);
      end
      checks++; if (busy_b !== (f == 1)) begin
        errors++; $display("FAIL mid_boundary_busy frame=%0d got=%b exp=%b", f, busy_b, f == 1);
      end
    end
  endtask

  task automatic test_reset_mid_ramp;
    bit ok;
    int high;
    reset_b = 1'b1; locked_b = 1'b1;
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    wait_fs(1, ok);
    wait_fs(1, ok);
    checks++; if (!ok || pulse_b !== WB'(24)) begin errors++; $display("FAIL rst_pre_pulse got=%0d exp=24", pulse_b); end
    repeat (30) @(negedge clk);
    checks++; if (servo_b !== 1'b1) begin errors++; $display("FAIL rst_pre_servo got=%b exp=1", servo_b); end
    reset_b = 1'b1;
    @(negedge clk);
    checks++; if (pulse_b !== WB'(10)) begin errors++; $display("FAIL rst_pulse got=%0d exp=10", pulse_b); end
    checks++; if (servo_b !== 1'b0) begin errors++; $display("FAIL rst_servo got=%b exp=0", servo_b); end
    checks++; if (dut_b.us_cnt !== '0) begin errors++; $display("FAIL rst_us_cnt got=%0d exp=0", dut_b.us_cnt); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_b); end
    locked_b = 1'b0; reset_b = 1'b0;
    high = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (servo_b === 1'b1) high++;
      if (i == 200) begin
        checks++; if (fs_b !== 1'b1) begin errors++; $display("FAIL rst_frame_end got=%b exp=1", fs_b); end
      end
    end
    checks++; if (high != 20) begin errors++; $display("FAIL rst_high got=%0d exp=20", high); end
  endtask

  task automatic test_period;
    int n;
    for (int f = 0; f < 10; f++) begin
      n = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        n++;
        if (fs_b === 1'b1) break;
      end
      checks++; if (n != 200) begin errors++; $display("FAIL period frame=%0d got=%0d exp=200", f, n); end
    end
  endtask

  task automatic test_equal;
    int bad_busy;
    int bad_pulse;
    reset_c = 1'b1;
    repeat (2) @(negedge clk);
    reset_c = 1'b0;
    bad_busy = 0; bad_pulse = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i % 7 == 0) locked_c = ~locked_c;
      if (busy_c !== 1'b0) bad_busy++;
      if (pulse_c !== WC'(10)) bad_pulse++;
    end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL equal_busy got=%0d exp=0", bad_busy); end
    checks++; if (bad_pulse != 0) begin errors++; $display("FAIL equal_pulse got=%0d exp=0", bad_pulse); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_lock_ramp();
    test_reversal();
    test_mid_frame();
    test_reset_mid_ramp();
    test_period();
    test_equal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
